// File: rtl/ysyx_22050243_id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding controller.
// Operand-select encodings driven onto the ID operand muxes.
package ysyx_22050243_id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,  // register file
    FWD_MEM  = 2'b01,  // EX/MEM result
    FWD_WB   = 2'b10,  // MEM/WB result
    FWD_DONE = 2'b11   // long-op completion bus
  } fwd_e;

endpackage

// File: rtl/ysyx_22050243_wb_scoreboard.sv
// Scoreboard of outstanding long-latency writebacks: allocate, release,
// per-source match, occupancy and a sticky error on an unmatched completion.
module ysyx_22050243_wb_scoreboard #(
  parameter int W       = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  input  logic [W-1:0]           alloc_rd,
  input  logic                   done_valid,
  input  logic [W-1:0]           done_rd,
  input  logic [NUM_SRC*W-1:0]   src,
  output logic [NUM_SRC-1:0]     hit,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     rd_q [DEPTH];
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] rel_oh;
  logic             alloc_go;

  // Walking from the top down leaves the lowest qualifying index selected.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    free_oh = '0;
    rel_oh  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
      if (done_valid && valid_q[i] && rd_q[i] == done_rd) begin
        rel_oh    = '0;
        rel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(valid_q[i]);
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign alloc_go = alloc_req & ~full;

  always_comb begin
    hit = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && rd_q[i] == src[s*W +: W]) hit[s] = 1'b1;
      end
    end
  end

  // Allocation only targets free entries and release only valid ones, so the
  // two one-hot vectors never overlap and both can apply in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      valid_q <= '0;
      err     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_go && free_oh[i]) valid_q[i] <= 1'b1;
        else if (rel_oh[i])         valid_q[i] <= 1'b0;
      end
      if (done_valid && rel_oh == '0) err <= 1'b1;
    end
  end

  // NOTE: the rd payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && alloc_go && free_oh[i]) rd_q[i] <= alloc_rd;
    end
  end

endmodule

// File: rtl/ysyx_22050243_id_hazard_ctrl.sv
// ID-stage hazard and forwarding controller: per-slot priority resolution of
// operand sources, front-end stall generation and a stalled-cycle counter.
module ysyx_22050243_id_hazard_ctrl
  import ysyx_22050243_id_hazard_ctrl_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int PEND_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [NUM_SRC*GPR_ADDR_WIDTH-1:0]   id_src,
  input  logic [NUM_SRC-1:0]                  id_src_used,
  input  logic                                id_is_ctrl,
  input  logic                                id_long,
  input  logic [GPR_ADDR_WIDTH-1:0]           ex_rd,
  input  logic                                ex_reg_w,
  input  logic                                ex_mem_r,
  input  logic                                ex_long,
  input  logic                                ex_adv,
  input  logic [GPR_ADDR_WIDTH-1:0]           mem_rd,
  input  logic                                mem_reg_w,
  input  logic                                mem_mem_r,
  input  logic [GPR_ADDR_WIDTH-1:0]           wb_rd,
  input  logic                                wb_reg_w,
  input  logic                                done_valid,
  input  logic [GPR_ADDR_WIDTH-1:0]           done_rd,
  output logic [NUM_SRC*2-1:0]                fwd_sel,
  output logic                                stall,
  output logic [$clog2(PEND_DEPTH):0]         pend_count,
  output logic                                pend_full,
  output logic                                sb_err,
  output logic [31:0]                         stall_cycles
);

  localparam int W = GPR_ADDR_WIDTH;

  logic [NUM_SRC-1:0] sb_hit;
  logic [NUM_SRC-1:0] slot_stall;
  logic               alloc_req;

  assign alloc_req = ex_adv & ex_long & ex_reg_w & (ex_rd != '0);

  ysyx_22050243_wb_scoreboard #(
    .W       (W),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (PEND_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_rd   (ex_rd),
    .done_valid (done_valid),
    .done_rd    (done_rd),
    .src        (id_src),
    .hit        (sb_hit),
    .count      (pend_count),
    .full       (pend_full),
    .err        (sb_err)
  );

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    logic [W-1:0] src;
    logic         active;
    logic         st;
    fwd_e         fw;

    assign src    = id_src[s*W +: W];
    assign active = id_valid & id_src_used[s] & (src != '0);

    // Non-ctrl consumers only care about load-use here; the EX forwarding
    // unit supplies their other operands one stage later.
    always_comb begin
      st = 1'b0;
      fw = FWD_RF;
      if (active) begin
        if (sb_hit[s]) begin
          if (done_valid && done_rd == src) fw = FWD_DONE;
          else                              st = 1'b1;
        end else if (id_is_ctrl && ex_reg_w && ex_rd == src) begin
          st = 1'b1;
        end else if (ex_mem_r && ex_rd == src) begin
          st = 1'b1;
        end else if (id_is_ctrl && mem_mem_r && mem_rd == src) begin
          st = 1'b1;
        end else if (id_is_ctrl && mem_reg_w && !mem_mem_r && mem_rd == src) begin
          fw = FWD_MEM;
        end else if (id_is_ctrl && wb_reg_w && wb_rd == src) begin
          fw = FWD_WB;
        end
      end
    end

    assign slot_stall[s]      = st;
    assign fwd_sel[2*s +: 2]  = fw;
  end

  assign stall = (|slot_stall) | (id_valid & id_long & pend_full);

  always_ff @(posedge clk) begin
    if (rst)                               stall_cycles <= '0;
    else if (stall && stall_cycles != '1)  stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_ysyx_22050243_id_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized cycles, all checked
// against a queue-based model of the scoreboard and the forwarding rules.
module tb_ysyx_22050243_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_is_ctrl;
  logic        id_long;
  logic [4:0]  ex_rd;
  logic        ex_reg_w;
  logic        ex_mem_r;
  logic        ex_long;
  logic        ex_adv;
  logic [4:0]  mem_rd;
  logic        mem_reg_w;
  logic        mem_mem_r;
  logic [4:0]  wb_rd;
  logic        wb_reg_w;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [2:0]  pend_count;
  logic        pend_full;
  logic        sb_err;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: scoreboard as an unordered multiset of pending rd values.
  logic [4:0]  m_pend[$];
  bit          m_err = 1'b0;
  logic [31:0] m_cycles = '0;

  ysyx_22050243_id_hazard_ctrl #(
    .GPR_ADDR_WIDTH (5),
    .NUM_SRC        (2),
    .PEND_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_is_ctrl   (id_is_ctrl),
    .id_long      (id_long),
    .ex_rd        (ex_rd),
    .ex_reg_w     (ex_reg_w),
    .ex_mem_r     (ex_mem_r),
    .ex_long      (ex_long),
    .ex_adv       (ex_adv),
    .mem_rd       (mem_rd),
    .mem_reg_w    (mem_reg_w),
    .mem_mem_r    (mem_mem_r),
    .wb_rd        (wb_rd),
    .wb_reg_w     (wb_reg_w),
    .done_valid   (done_valid),
    .done_rd      (done_rd),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .pend_count   (pend_count),
    .pend_full    (pend_full),
    .sb_err       (sb_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit in_pend(logic [4:0] a);
    foreach (m_pend[i]) if (m_pend[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval(output bit st, output logic [3:0] fw);
    logic [4:0] a;
    logic [1:0] f;
    bit         ss;
    st = 1'b0;
    fw = '0;
    for (int s = 0; s < 2; s++) begin
      a  = id_src[s*5 +: 5];
      f  = 2'b00;
      ss = 1'b0;
      if (id_valid && id_src_used[s] && a != 5'd0) begin
        if (in_pend(a)) begin
          if (done_valid && done_rd == a) f = 2'b11;
          else                            ss = 1'b1;
        end
        else if (id_is_ctrl && ex_reg_w && ex_rd == a)  ss = 1'b1;
        else if (ex_mem_r && ex_rd == a)                ss = 1'b1;
        else if (id_is_ctrl && mem_mem_r && mem_rd == a) ss = 1'b1;
        else if (id_is_ctrl && mem_reg_w && mem_rd == a) f = 2'b01;
        else if (id_is_ctrl && wb_reg_w && wb_rd == a)   f = 2'b10;
      end
      st = st | ss;
      fw[s*2 +: 2] = f;
    end
    if (id_valid && id_long && m_pend.size() == 4) st = 1'b1;
  endfunction

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic step();
    bit         st;
    logic [3:0] fw;
    bit         was_full;
    int         idx;
    model_eval(st, fw);
    if (rst) begin
      m_pend.delete();
      m_err    = 1'b0;
      m_cycles = '0;
    end else begin
      was_full = (m_pend.size() == 4);
      if (st && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
      if (done_valid) begin
        idx = -1;
        foreach (m_pend[i]) if (idx < 0 && m_pend[i] == done_rd) idx = i;
        if (idx >= 0) m_pend.delete(idx);
        else          m_err = 1'b1;
      end
      if (ex_adv && ex_long && ex_reg_w && ex_rd != 5'd0 && !was_full)
        m_pend.push_back(ex_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src = '0; id_src_used = '0; id_is_ctrl = 0; id_long = 0;
    ex_rd = '0; ex_reg_w = 0; ex_mem_r = 0; ex_long = 0; ex_adv = 0;
    mem_rd = '0; mem_reg_w = 0; mem_mem_r = 0; wb_rd = '0; wb_reg_w = 0;
    done_valid = 0; done_rd = '0;
  endtask

  task automatic alloc_in(logic [4:0] rd);
    ex_adv = 1; ex_long = 1; ex_reg_w = 1; ex_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    step(); step();
    n_checks++; if (pend_count !== 3'd0) begin n_errors++; $display("FAIL reset_count got=%0d want=0", pend_count); end
    n_checks++; if (pend_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b want=0", pend_full); end
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", sb_err); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_errors++; $display("FAIL reset_cycles got=%0d want=0", stall_cycles); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    id_valid = 1; id_is_ctrl = 1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01; ex_rd = 5'd5; ex_reg_w = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_comb_stall got=%b want=1", stall); end
    step();
    rst = 0; idle();
    #1;
  endtask

  task automatic test_ctrl_ex();
    idle();
    id_valid = 1; id_is_ctrl = 1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    ex_rd = 5'd5; ex_reg_w = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL ctrl_ex_stall got=%b want=1", stall); end
    step();
    n_checks++; if (stall_cycles !== m_cycles) begin n_errors++; $display("FAIL ctrl_ex_cycles got=%0d want=%0d", stall_cycles, m_cycles); end
    ex_rd = '0; ex_reg_w = 0; mem_rd = 5'd5; mem_reg_w = 1; mem_mem_r = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL ctrl_mem_stall got=%b want=0", stall); end
    n_checks++; if (fwd_sel[1:0] !== 2'b01) begin n_errors++; $display("FAIL ctrl_mem_fwd got=%b want=01", fwd_sel[1:0]); end
    wb_rd = 5'd5; wb_reg_w = 1;
    #1;
    n_checks++; if (fwd_sel[1:0] !== 2'b01) begin n_errors++; $display("FAIL ctrl_mem_over_wb got=%b want=01", fwd_sel[1:0]); end
    step();
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_src = {5'd7, 5'd0}; id_src_used = 2'b10;
    ex_rd = 5'd7; ex_reg_w = 1; ex_mem_r = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL load_use_stall got=%b want=1", stall); end
    step();
    ex_rd = '0; ex_reg_w = 0; ex_mem_r = 0; mem_rd = 5'd7; mem_reg_w = 1; mem_mem_r = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL load_mem_stall got=%b want=0", stall); end
    n_checks++; if (fwd_sel[3:2] !== 2'b00) begin n_errors++; $display("FAIL load_mem_fwd got=%b want=00", fwd_sel[3:2]); end
    id_is_ctrl = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL ctrl_load_mem_stall got=%b want=1", stall); end
    step();
  endtask

  task automatic test_long_op();
    idle(); alloc_in(5'd9);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL long_alloc_stall got=%b want=0", stall); end
    step();
    idle(); id_valid = 1; id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL long_pend_stall got=%b want=1", stall); end
    n_checks++; if (pend_count !== 3'd1) begin n_errors++; $display("FAIL long_count got=%0d want=1", pend_count); end
    step();
    done_valid = 1; done_rd = 5'd9;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL long_done_stall got=%b want=0", stall); end
    n_checks++; if (fwd_sel[1:0] !== 2'b11) begin n_errors++; $display("FAIL long_done_fwd got=%b want=11", fwd_sel[1:0]); end
    step();
    done_valid = 0; done_rd = '0;
    #1;
    n_checks++; if (pend_count !== 3'd0) begin n_errors++; $display("FAIL long_freed got=%0d want=0", pend_count); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL long_after_stall got=%b want=0", stall); end
    step();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      idle(); alloc_in(5'(r)); step();
    end
    idle(); id_valid = 1; id_long = 1;
    #1;
    n_checks++; if (pend_count !== 3'd4) begin n_errors++; $display("FAIL full_count got=%0d want=4", pend_count); end
    n_checks++; if (pend_full !== 1'b1) begin n_errors++; $display("FAIL full_flag got=%b want=1", pend_full); end
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL full_stall got=%b want=1", stall); end
    idle(); alloc_in(5'd5); done_valid = 1; done_rd = 5'd4;
    step();
    idle(); #1;
    n_checks++; if (pend_count !== 3'd3) begin n_errors++; $display("FAIL full_refuse got=%0d want=3", pend_count); end
    alloc_in(5'd6); done_valid = 1; done_rd = 5'd1;
    step();
    idle(); #1;
    n_checks++; if (pend_count !== 3'd3) begin n_errors++; $display("FAIL alloc_rel_same got=%0d want=3", pend_count); end
    id_valid = 1; id_src = {5'd6, 5'd1}; id_src_used = 2'b11;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL full_new_entry_stall got=%b want=1", stall); end
    foreach (m_pend[i]) ; // keep model in sync via step only
    idle(); done_valid = 1; done_rd = 5'd2; step();
    done_rd = 5'd3; step();
    done_rd = 5'd6; step();
    idle(); #1;
    n_checks++; if (pend_count !== 3'd0) begin n_errors++; $display("FAIL full_drain got=%0d want=0", pend_count); end
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL full_no_err got=%b want=0", sb_err); end
  endtask

  task automatic test_err_reset();
    idle(); done_valid = 1; done_rd = 5'd12;
    step();
    idle(); #1;
    n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL err_set got=%b want=1", sb_err); end
    alloc_in(5'd8); step();
    idle(); id_valid = 1; id_is_ctrl = 1; id_src = {5'd0, 5'd8}; id_src_used = 2'b01;
    step(); step();
    n_checks++; if (sb_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got=%b want=1", sb_err); end
    n_checks++; if (stall_cycles !== m_cycles) begin n_errors++; $display("FAIL err_cycles got=%0d want=%0d", stall_cycles, m_cycles); end
    n_checks++; if (pend_count !== 3'd1) begin n_errors++; $display("FAIL err_count got=%0d want=1", pend_count); end
    rst = 1; alloc_in(5'd10); done_valid = 1; done_rd = 5'd8;
    step();
    rst = 0; idle(); #1;
    n_checks++; if (pend_count !== 3'd0) begin n_errors++; $display("FAIL mid_rst_count got=%0d want=0", pend_count); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_errors++; $display("FAIL mid_rst_cycles got=%0d want=0", stall_cycles); end
    n_checks++; if (sb_err !== 1'b0) begin n_errors++; $display("FAIL mid_rst_err got=%b want=0", sb_err); end
  endtask

  task automatic test_zero_and_dual_wb();
    idle();
    id_valid = 1; id_is_ctrl = 1; id_src = '0; id_src_used = 2'b11;
    ex_rd = '0; ex_reg_w = 1; ex_mem_r = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL zero_stall got=%b want=0", stall); end
    n_checks++; if (fwd_sel !== 4'b0000) begin n_errors++; $display("FAIL zero_fwd got=%b want=0000", fwd_sel); end
    step();
    idle();
    id_valid = 1; id_is_ctrl = 1; id_src = {5'd3, 5'd3}; id_src_used = 2'b11;
    wb_rd = 5'd3; wb_reg_w = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL dual_wb_stall got=%b want=0", stall); end
    n_checks++; if (fwd_sel !== 4'b1010) begin n_errors++; $display("FAIL dual_wb_fwd got=%b want=1010", fwd_sel); end
    id_src_used = 2'b01;
    #1;
    n_checks++; if (fwd_sel !== 4'b0010) begin n_errors++; $display("FAIL unused_slot_fwd got=%b want=0010", fwd_sel); end
    step();
  endtask

  task automatic test_random();
    bit         est;
    logic [3:0] efw;
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 49) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_used = 2'($urandom_range(0, 3));
      id_is_ctrl  = ($urandom_range(0, 1) == 1);
      id_long     = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      ex_reg_w    = ($urandom_range(0, 1) == 1);
      ex_mem_r    = ($urandom_range(0, 3) == 0);
      ex_long     = ($urandom_range(0, 1) == 1);
      ex_adv      = ($urandom_range(0, 1) == 1);
      mem_rd      = 5'($urandom_range(0, 7));
      mem_reg_w   = ($urandom_range(0, 1) == 1);
      mem_mem_r   = ($urandom_range(0, 3) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_reg_w    = ($urandom_range(0, 1) == 1);
      done_valid  = ($urandom_range(0, 2) == 0);
      if (m_pend.size() > 0 && $urandom_range(0, 3) != 0)
        done_rd = m_pend[$urandom_range(0, m_pend.size() - 1)];
      else
        done_rd = 5'($urandom_range(0, 15));
      #1;
      model_eval(est, efw);
      n_checks++; if (stall !== est) begin n_errors++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", c, stall, est); end
      if (!est) begin
        n_checks++; if (fwd_sel !== efw) begin n_errors++; $display("FAIL rnd_fwd cyc=%0d got=%b want=%b", c, fwd_sel, efw); end
      end
      n_checks++; if (pend_count !== 3'(m_pend.size())) begin n_errors++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, pend_count, m_pend.size()); end
      n_checks++; if (pend_full !== (m_pend.size() == 4)) begin n_errors++; $display("FAIL rnd_full cyc=%0d got=%b", c, pend_full); end
      n_checks++; if (sb_err !== m_err) begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", c, sb_err, m_err); end
      n_checks++; if (stall_cycles !== m_cycles) begin n_errors++; $display("FAIL rnd_cycles cyc=%0d got=%0d want=%0d", c, stall_cycles, m_cycles); end
      step();
    end
    rst = 0; idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_ctrl_ex();
    test_load_use();
    test_long_op();
    test_full();
    test_err_reset();
    test_zero_and_dual_wb();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_id_hazard_ctrl.md
# ysyx_22050243_id_hazard_ctrl

ID-stage hazard and forwarding controller: the parametrised successor of the single-operand JALR hazard detector. It covers NUM_SRC source operands, branch/JALR operands resolved in ID, load-use stalls, and a scoreboard of outstanding long-latency writebacks (mul/div, variable-latency LSU). It sits between the IF/ID register and the ID stage, and drives ID operand muxes plus the front-end stall.

## Interface
- GPR_ADDR_WIDTH, 5, register-address width
- NUM_SRC, 2, source operands examined per ID instruction
- PEND_DEPTH, 4, scoreboard entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  IF/ID holds a valid instruction
- id_src  in  NUM_SRC*GPR_ADDR_WIDTH  source addresses; slot i at [i*W +: W]
- id_src_used  in  NUM_SRC  slot i is actually read
- id_is_ctrl  in  1  branch/JALR; operands needed in ID
- id_long  in  1  ID instruction is a long-latency op
- ex_rd, ex_reg_w, ex_mem_r, ex_long  in  W,1,1,1  ID/EX register contents
- ex_adv  in  1  ID/EX contents move into EX/MEM this cycle
- mem_rd, mem_reg_w, mem_mem_r  in  W,1,1  EX/MEM register contents
- wb_rd, wb_reg_w  in  W,1  MEM/WB register contents
- done_valid, done_rd  in  1,W  long-op completion/writeback bus
- fwd_sel  out  NUM_SRC*2  per-slot operand select
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- pend_count  out  clog2(PEND_DEPTH)+1  occupied entries
- pend_full  out  1  pend_count == PEND_DEPTH
- sb_err  out  1  sticky: completion with no matching entry
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- Address 0 never hazards, never forwards (fwd 00) and is never allocated.
- A slot is active when id_valid & id_src_used[i] & src≠0. Inactive slots: fwd 00, no stall contribution.
- fwd_sel encoding: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 done bus.
- Per active slot, in this priority:
  1. Match on a valid scoreboard entry: done_valid & done_rd==src → fwd 11, no stall; otherwise stall.
  2. id_is_ctrl & ex_reg_w & ex_rd==src → stall. EX result is not yet available.
  3. ex_mem_r & ex_rd==src → stall. This is load-use, for any instruction.
  4. id_is_ctrl & mem_mem_r & mem_rd==src → stall.
  5. id_is_ctrl & mem_reg_w & !mem_mem_r & mem_rd==src → fwd 01.
  6. id_is_ctrl & wb_reg_w & wb_rd==src → fwd 10.
  7. Otherwise fwd 00. Non-ctrl instructions get EX operands from the EX forwarding unit.
- stall = OR of per-slot stalls, OR (id_valid & id_long & pend_full).
- While stall=1, fwd_sel is still driven but is don't-care.
- Scoreboard holds PEND_DEPTH {valid, rd} entries. Duplicates of the same rd are allowed.
  - Allocate: ex_adv & ex_long & ex_reg_w & ex_rd≠0 & !pend_full → lowest free entry.
  - Release: done_valid → lowest-index valid entry with rd==done_rd. If none exists, set sb_err; nothing is freed.
- Allocate and release in the same cycle both take effect, and pend_count is unchanged. A full table with a simultaneous release still refuses the allocation; upstream id_long stalling guarantees this case does not arise.
- stall_cycles increments every cycle stall=1 and saturates at 0xFFFF_FFFF.

## Timing
- All hazard and fwd outputs are combinational from inputs and current state. There are no registered outputs except the state-derived ones.
- Scoreboard, sb_err and stall_cycles update on the rising clk edge.
  - An entry allocated at edge N first causes stalls in cycle N+1.
  - A release at edge N removes the stall the same cycle via fwd 11. The entry is gone from N+1.
- Reset (rst=1 at an edge) clears all entries, pend_count=0, pend_full=0, sb_err=0, stall_cycles=0. This applies mid-operation; allocate and release inputs in that cycle are ignored.
- Combinational outputs while in reset: stall depends only on pipeline inputs, since the scoreboard is empty.

## Structure
- Shared package/header holds:
  - FWD_RF/FWD_MEM/FWD_WB/FWD_DONE encodings
  - opcode defines such as `JALR`, already global
- A natural sub-module is ysyx_22050243_wb_scoreboard: the entry array, allocate/release, match vector per slot, count, full and err.
- The top level holds the priority logic, generated per slot, plus the perf counter.

## Test plan
- Ctrl instruction, src1=5, ex_rd=5, ex_reg_w=1 → stall=1, stall_cycles +1. Next cycle with rd=5 in EX/MEM, non-load → stall=0, fwd slot0=01.
- Non-ctrl, src2=7, ex_rd=7, ex_mem_r=1 → stall=1. Same with the load in EX/MEM → stall=0, fwd slot1=00.
- Allocate ex_rd=9 long. Next cycle ID reads x9 → stall=1. Cycle with done_valid, done_rd=9 → stall=0, fwd=11. Following cycle pend_count=0.
- Fill 4 entries (rd 1,2,3,4); ID id_long=1 → pend_full=1, stall=1. Allocate+release in the same cycle from 3 entries → count stays 3.
- done_valid with done_rd=12 and no such entry → sb_err=1 and stays 1 until rst. rst mid-operation → pend_count=0, stall_cycles=0.
- src=0 against ex_rd=0, ex_mem_r=1 → stall=0, fwd=00. Two slots both hitting WB rd=3 on a ctrl instruction → both fwd=10.
